// File: rtl/ot_read.sv
// ot_read: drains entries 0..fin of the output SRAM onto a valid/ready stream.
// Reads are throttled so the 2-entry output buffer (head + skid) can never overflow.
module ot_read #(
   parameter int SRAM_DATA_BITS = 64,
   parameter int SRAM_ADDR_BITS = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [SRAM_ADDR_BITS-1:0] cfg_ot_rnd_finsub1,
   output logic                      cen_otsr,
   output logic                      wen_otsr,
   output logic [SRAM_ADDR_BITS-1:0] addr_otsr,
   input  logic [SRAM_DATA_BITS-1:0] data_from_sram,
   output logic [SRAM_DATA_BITS-1:0] m_tdata,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic                      m_tlast,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

   state_t                    state_r;
   logic [SRAM_ADDR_BITS-1:0] fin_r;
   logic [SRAM_ADDR_BITS-1:0] rd_addr_r;
   logic [SRAM_ADDR_BITS-1:0] addr_hold_r;
   logic                      inflight_r;
   logic                      inflight_last_r;
   logic                      skid_valid_r;
   logic                      skid_last_r;
   logic [SRAM_DATA_BITS-1:0] skid_data_r;
   logic                      busy_r;
   logic                      done_r;
   logic [1:0]                occ_s;
   logic                      pop_s;
   logic                      issue_s;
   logic                      issue_last_s;

   // Issue decision: SRAM access has to be decided in the same cycle it is driven.
   always_comb begin
      pop_s        = m_tvalid & m_tready;
      occ_s        = {1'b0, m_tvalid} + {1'b0, skid_valid_r};
      issue_s      = 1'b0;
      issue_last_s = 1'b0;
      if (state_r == READ) begin
         issue_s      = (({1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s}) < 3'd2);
         issue_last_s = issue_s & (rd_addr_r == fin_r);
      end else begin
         issue_s      = 1'b0;
         issue_last_s = 1'b0;
      end
   end

   assign cen_otsr  = ~issue_s;
   assign wen_otsr  = 1'b1;
   assign addr_otsr = issue_s ? rd_addr_r : addr_hold_r;
   assign busy      = busy_r;
   assign done      = done_r;

   // Round sequencing: address generation, read tracking, busy/done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= IDLE;
         fin_r           <= {SRAM_ADDR_BITS{1'b0}};
         rd_addr_r       <= {SRAM_ADDR_BITS{1'b0}};
         addr_hold_r     <= {SRAM_ADDR_BITS{1'b0}};
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
      end else begin
         inflight_r      <= issue_s;
         inflight_last_r <= issue_last_s;
         done_r          <= 1'b0;
         if (issue_s) begin
            addr_hold_r <= rd_addr_r;
            rd_addr_r   <= rd_addr_r + {{(SRAM_ADDR_BITS-1){1'b0}}, 1'b1};
         end
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r   <= READ;
                  fin_r     <= cfg_ot_rnd_finsub1;
                  rd_addr_r <= {SRAM_ADDR_BITS{1'b0}};
                  busy_r    <= 1'b1;
               end
            end
            READ: begin
               if (issue_last_s) begin
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               // The tlast beat is the final read, so its transfer empties the pipe.
               if (done_r) begin
                  state_r <= IDLE;
               end else if (pop_s && m_tlast) begin
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Output buffer: head register drives the stream, skid holds one more beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_tvalid     <= 1'b0;
         m_tdata      <= {SRAM_DATA_BITS{1'b0}};
         m_tlast      <= 1'b0;
         skid_valid_r <= 1'b0;
         skid_data_r  <= {SRAM_DATA_BITS{1'b0}};
         skid_last_r  <= 1'b0;
      end else if (pop_s || !m_tvalid) begin
         if (skid_valid_r) begin
            m_tvalid     <= 1'b1;
            m_tdata      <= skid_data_r;
            m_tlast      <= skid_last_r;
            skid_valid_r <= inflight_r;
            skid_data_r  <= data_from_sram;
            skid_last_r  <= inflight_last_r;
         end else begin
            m_tvalid <= inflight_r;
            m_tlast  <= inflight_r & inflight_last_r;
            if (inflight_r) begin
               m_tdata <= data_from_sram;
            end
         end
      end else if (inflight_r) begin
         skid_valid_r <= 1'b1;
         skid_data_r  <= data_from_sram;
         skid_last_r  <= inflight_last_r;
      end
   end

   ot_read_chk u_chk (
      .clk        (clk),
      .reset      (reset),
      .head_valid (m_tvalid),
      .skid_valid (skid_valid_r),
      .incoming   (inflight_r),
      .pop        (pop_s),
      .tlast      (m_tlast)
   );

endmodule

// ot_read_chk: buffer-overflow and stream-framing properties for ot_read.
module ot_read_chk (
   input logic clk,
   input logic reset,
   input logic head_valid,
   input logic skid_valid,
   input logic incoming,
   input logic pop,
   input logic tlast
);

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(head_valid && skid_valid && incoming && !pop));

   a_tlast_with_valid: assert property (@(posedge clk) disable iff (reset)
      !(tlast && !head_valid));

endmodule

// File: tb/tb_ot_read.sv
// Scoreboard bench for ot_read: a small SRAM model, a per-round list of expected beats,
// and a negedge monitor that checks beats, stalls, read throttling and done framing.
module tb_ot_read;
   localparam int DB = 64;
   localparam int AB = 10;

   logic          clk = 1'b0;
   logic          reset, start, cen, wen, m_tvalid, m_tready, m_tlast, busy, done;
   logic [AB-1:0] cfg, addr;
   logic [DB-1:0] rdata, m_tdata;

   always #5 clk = ~clk;

   ot_read #(.SRAM_DATA_BITS(DB), .SRAM_ADDR_BITS(AB)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_ot_rnd_finsub1(cfg),
      .cen_otsr(cen), .wen_otsr(wen), .addr_otsr(addr), .data_from_sram(rdata),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .busy(busy), .done(done)
   );

   logic [DB-1:0] mem [0:1023];
   always @(posedge clk) if (!cen) rdata <= mem[addr];

   typedef struct packed { logic [DB-1:0] data; logic last; } beat_t;
   beat_t exp_q[$];

   int checks = 0, errors = 0, cyc = 0;
   bit model_idle = 1'b1, exp_done = 1'b0;
   int acc_cyc = 0, fin_round = 0, issued_round = 0, beats_round = 0, last_xfer_cyc = 0;
   int out_cnt = 0, done_cnt = 0, rounds_done_exp = 0, ready_mode = 0;
   bit seen_issue = 1'b0, seen_valid = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
   logic [DB-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: decoupled from stimulus, compares everything the DUT presents.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
         out_cnt    = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", m_tvalid, 1);
            chk("stall_data", m_tdata, prev_data);
            chk("stall_last", m_tlast, prev_last);
         end
         if (!cen) begin
            issued_round++;
            out_cnt++;
            chk("wen_high", wen, 1);
            if (!seen_issue) begin
               seen_issue = 1'b1;
               chk("first_issue_latency", cyc - acc_cyc, 1);
            end
         end
         if (m_tvalid && !seen_valid && !model_idle) begin
            seen_valid = 1'b1;
            chk("first_valid_latency", cyc - acc_cyc, 3);
         end
         if (done) done_cnt++;
         if (exp_done) begin
            chk("done_pulse", done, 1);
            chk("busy_low_at_done", busy, 0);
            chk("reads_per_round", issued_round, fin_round + 1);
            exp_done   = 1'b0;
            model_idle = 1'b1;
         end else if (done) begin
            chk("unexpected_done", done, 0);
         end
         if (m_tvalid && m_tready) begin
            out_cnt--;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("tdata", m_tdata, b.data);
               chk("tlast", m_tlast, b.last);
               chk("busy_during_round", busy, 1);
               if (ready_mode == 0 && beats_round > 0)
                  chk("beat_gap", cyc - last_xfer_cyc, 1);
               last_xfer_cyc = cyc;
               beats_round++;
               if (b.last) exp_done = 1'b1;
            end
         end
         if (!cen) chk("outstanding_le2", out_cnt <= 2, 1);
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
   end

   // Consumer ready pattern.
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
         endcase
      end
   end

   // Called 1 time unit after a rising edge; the reference model is just mem[0..fin].
   task automatic do_start(input int fin);
      beat_t b;
      start = 1'b1;
      cfg   = fin[AB-1:0];
      if (model_idle) begin
         model_idle   = 1'b0;
         acc_cyc      = cyc;
         fin_round    = fin;
         issued_round = 0;
         beats_round  = 0;
         seen_issue   = 1'b0;
         seen_valid   = 1'b0;
         rounds_done_exp++;
         for (int i = 0; i <= fin; i++) begin
            b.data = mem[i];
            b.last = (i == fin);
            exp_q.push_back(b);
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (model_idle) return;
         @(posedge clk); #1;
      end
      chk("round_timeout", model_idle, 1);
   endtask

   task automatic check_reset_vals();
      chk("rst_cen", cen, 1);
      chk("rst_wen", wen, 1);
      chk("rst_addr", addr, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; cfg = '0;
      for (int i = 0; i < 1024; i++) mem[i] = DB'(i);
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      reset = 1'b0;
      @(posedge clk); #1;

      // Full-rate round, data = address
      ready_mode = 0;
      do_start(127);
      wait_idle(400);

      for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};

      // Single-entry round
      do_start(0);
      wait_idle(50);
      @(posedge clk); #1;

      // Random backpressure
      ready_mode = 1;
      do_start(15);
      wait_idle(400);
      for (int r = 0; r < 4; r++) begin
         do_start(int'($urandom_range(0, 40)));
         wait_idle(800);
      end

      // Consumer held off: throttling must stop at two reads
      ready_mode = 2;
      do_start(15);
      repeat (20) @(posedge clk);
      #1;
      chk("reads_while_stalled", issued_round, 2);
      chk("cen_idle_while_stalled", cen, 1);
      ready_mode = 0;
      wait_idle(200);

      // Ignored second start, then reset mid-round
      do_start(31);
      @(posedge clk); #1;
      do_start(5);
      for (int i = 0; i < 200 && beats_round < 5; i++) begin
         @(posedge clk); #1;
      end
      chk("reached_beat5", beats_round >= 5, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_vals();
      reset = 1'b0;
      exp_q.delete();
      exp_done   = 1'b0;
      model_idle = 1'b1;
      rounds_done_exp--;
      @(posedge clk); #1;
      do_start(9);
      wait_idle(200);

      // Back-to-back rounds with cfg changed during the first
      do_start(7);
      repeat (3) @(posedge clk);
      #1;
      cfg = 10'd3;
      wait_idle(200);
      do_start(3);
      wait_idle(200);

      // Full address space
      do_start(1023);
      wait_idle(1200);

      repeat (5) @(posedge clk);
      #1;
      chk("done_count", done_cnt, rounds_done_exp);
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
